// File: rtl/matrix_scan_scheduler.sv
// Column-multiplexed scan of a 5x7 LED matrix with blanking gaps.
// Image choice (A/B/alert) is latched only at frame start, so frames never tear.
module matrix_scan_scheduler #(
    parameter int COLUMNS     = 5,
    parameter int ROWS        = 7,
    parameter int BLANK_TICKS = 1,
    parameter int DRIVE_TICKS = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    fast_tick,
    input  logic                    slow_tick,
    input  logic [COLUMNS*ROWS-1:0] image_a,
    input  logic [COLUMNS*ROWS-1:0] image_b,
    input  logic [COLUMNS*ROWS-1:0] image_alert,
    input  logic                    alert_req,
    output logic [COLUMNS-1:0]      column_select,
    output logic [ROWS-1:0]         row_data,
    output logic                    frame_done,
    output logic [1:0]              showing
);

    localparam int PIX  = COLUMNS * ROWS;
    localparam int CW   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int TMAX = (DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      col_idx, col_n;
    logic [TW-1:0]      tick_cnt, tick_n;
    logic               alt_sel, alt_n;
    logic [PIX-1:0]     frame_buf, buf_n;
    logic [COLUMNS-1:0] cs_n;
    logic [ROWS-1:0]    row_n;
    logic               fd_n;
    logic [1:0]         show_n;

    logic [PIX-1:0]     src_img;
    logic [1:0]         src_show;
    logic               blank_end;
    logic               drive_end;
    logic               latch_now;
    logic [PIX-1:0]     view;
    logic [PIX-1:0]     col_bits;

    always_comb begin
        src_img  = alert_req ? image_alert : (alt_sel ? image_b : image_a);
        src_show = alert_req ? 2'd2 : {1'b0, alt_sel};
        blank_end = fast_tick && (state == BLANK)
                  && (tick_cnt == TW'(BLANK_TICKS - 1));
        drive_end = fast_tick && (state == DRIVE)
                  && (tick_cnt == TW'(DRIVE_TICKS - 1));
        latch_now = blank_end && (col_idx == '0);
        // Column 0 must come from the image being latched on this same edge
        view     = latch_now ? src_img : frame_buf;
        col_bits = view >> (ROWS * int'(col_idx));
    end

    always_comb begin
        state_n = state;
        col_n   = col_idx;
        tick_n  = tick_cnt;
        alt_n   = alt_sel ^ slow_tick;
        buf_n   = frame_buf;
        cs_n    = column_select;
        row_n   = row_data;
        fd_n    = 1'b0;
        show_n  = showing;
        if (fast_tick) begin
            unique case (state)
                BLANK: begin
                    if (blank_end) begin
                        state_n = DRIVE;
                        tick_n  = '0;
                        cs_n    = COLUMNS'(1) << col_idx;
                        row_n   = col_bits[ROWS-1:0];
                        if (latch_now) begin
                            buf_n  = src_img;
                            show_n = src_show;
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
                DRIVE: begin
                    if (drive_end) begin
                        state_n = BLANK;
                        tick_n  = '0;
                        cs_n    = '0;
                        row_n   = '0;
                        if (col_idx == CW'(COLUMNS - 1)) begin
                            col_n = '0;
                            fd_n  = 1'b1;
                        end else begin
                            col_n = col_idx + CW'(1);
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
                default: state_n = BLANK;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BLANK;
            col_idx       <= '0;
            tick_cnt      <= '0;
            alt_sel       <= 1'b0;
            frame_buf     <= '0;
            column_select <= '0;
            row_data      <= '0;
            frame_done    <= 1'b0;
            showing       <= 2'd0;
        end else begin
            state         <= state_n;
            col_idx       <= col_n;
            tick_cnt      <= tick_n;
            alt_sel       <= alt_n;
            frame_buf     <= buf_n;
            column_select <= cs_n;
            row_data      <= row_n;
            frame_done    <= fd_n;
            showing       <= show_n;
        end
    end

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Scoreboard bench for matrix_scan_scheduler: expected strobes are queued
// per frame by the driver and checked by a monitor on each new strobe.
module tb_matrix_scan_scheduler;

    typedef struct packed {
        logic [4:0] cs;
        logic [6:0] row;
        logic [1:0] show;
    } strobe_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fast_tick = 1'b0;
    logic        slow_tick = 1'b0;
    logic [34:0] image_a = '0;
    logic [34:0] image_b = '0;
    logic [34:0] image_alert = '0;
    logic        alert_req = 1'b0;
    logic [4:0]  column_select;
    logic [6:0]  row_data;
    logic        frame_done;
    logic [1:0]  showing;

    strobe_t     exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          fd_count = 0;
    logic [4:0]  prev_cs = '0;
    int          run_len = 0;

    matrix_scan_scheduler dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .fast_tick     (fast_tick),
        .slow_tick     (slow_tick),
        .image_a       (image_a),
        .image_b       (image_b),
        .image_alert   (image_alert),
        .alert_req     (alert_req),
        .column_select (column_select),
        .row_data      (row_data),
        .frame_done    (frame_done),
        .showing       (showing)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push_frame(input logic [34:0] img, input logic [1:0] show,
                              input int ncols);
        strobe_t s;
        for (int c = 0; c < ncols; c++) begin
            s.cs   = 5'(1 << c);
            s.row  = img[c*7 +: 7];
            s.show = show;
            exp_q.push_back(s);
        end
    endtask

    task automatic tick(input bit slow_with, input bit slow_after);
        @(negedge clock);
        fast_tick = 1'b1;
        slow_tick = slow_with;
        @(negedge clock);
        fast_tick = 1'b0;
        slow_tick = slow_after;
        @(negedge clock);
        slow_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input int slow_at, input bit coll);
        for (int i = 1; i <= n; i++)
            tick(coll && (i == 1), i == slow_at);
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_cs = '0;
            run_len = 0;
        end else begin
            if (frame_done)
                fd_count++;
            if (column_select != '0 && column_select != prev_cs) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got cs=%b row=%b", column_select, row_data);
                end else begin
                    strobe_t e;
                    e = exp_q.pop_front();
                    check("strobe", {column_select, row_data, showing}, {e.cs, e.row, e.show});
                end
                run_len = 1;
            end else if (column_select != '0) begin
                run_len++;
            end else if (prev_cs != '0) begin
                check("strobe_len", run_len, 12);
                check("blank_row", row_data, 0);
            end
            prev_cs = column_select;
        end
    end

    initial begin
        for (int c = 0; c < 5; c++) begin
            image_a[c*7 +: 7]     = 7'(1 << c);
            image_b[c*7 +: 7]     = ~7'(1 << c);
            image_alert[c*7 +: 7] = 7'h55;
        end
        repeat (3) @(negedge clock);
        check("rst_cs", column_select, 0);
        check("rst_row", row_data, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check("idle_cs", column_select, 0);
        check("idle_row", row_data, 0);
        check("idle_show", showing, 0);
        check("idle_fd", fd_count, 0);

        // frame 1: A, slow_tick during column 2
        push_frame(image_a, 2'd0, 5);
        ticks(25, 12, 1'b0);
        // frame 2: B, alert raised mid-frame
        push_frame(image_b, 2'd1, 5);
        ticks(8, 0, 1'b0);
        alert_req = 1'b1;
        ticks(17, 0, 1'b0);
        // frame 3: alert; alert image edited and request dropped mid-frame
        push_frame(image_alert, 2'd2, 5);
        ticks(3, 0, 1'b0);
        for (int c = 0; c < 5; c++)
            image_alert[c*7 +: 7] = 7'h2A;
        ticks(7, 0, 1'b0);
        alert_req = 1'b0;
        ticks(15, 0, 1'b0);
        // frame 4: back to B, slow_tick sends alt_sel to 0
        push_frame(image_b, 2'd1, 5);
        ticks(25, 5, 1'b0);
        // frame 5: slow_tick coincides with the latch -> still A
        push_frame(image_a, 2'd0, 5);
        ticks(25, 0, 1'b1);
        // frame 6: B
        push_frame(image_b, 2'd1, 5);
        ticks(25, 0, 1'b0);
        // frame 7: B, reset during column 3 drive
        push_frame(image_b, 2'd1, 4);
        ticks(16, 0, 1'b0);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("async_cs", column_select, 0);
        check("async_row", row_data, 0);
        check("async_show", showing, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        // frame 8: restart at column 0 with A
        push_frame(image_a, 2'd0, 5);
        ticks(25, 0, 1'b0);
        repeat (4) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        check("frame_done_count", fd_count, 7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
